// File: rtl/estacao_reserva_r_pkg.sv
// Shared definitions for the R-type reservation station: ALU op codes,
// tag geometry and the tag ranges owned by each functional unit.
package estacao_reserva_r_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned OP_W   = 3;
  localparam int unsigned TAG_W_DEF = 3;

  typedef enum logic [OP_W-1:0] {
    ULA_ADD  = 3'd0,
    ULA_SUB  = 3'd1,
    ULA_SLT  = 3'd2,
    ULA_CMP  = 3'd3,
    ULA_ADD4 = 3'd4,
    ULA_SUB4 = 3'd5
  } ula_op_e;

  // Tag 0 means the operand value is already present.
  localparam logic [TAG_W_DEF-1:0] TAG_NULL = '0;

  localparam int unsigned BASE_TAG_R   = 1;
  localparam int unsigned BASE_TAG_MEM = 4;

endpackage

// File: rtl/estacao_reserva_r_rs_entry.sv
// One reservation-station entry: operand storage, issue-time CDB bypass
// and CDB snooping for operands still waiting on a producer tag.
module rs_entry
  import estacao_reserva_r_pkg::*;
#(
  parameter int unsigned TAG_W = TAG_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              issue_we_i,
  input  logic [OP_W-1:0]   issue_op_i,
  input  logic [DATA_W-1:0] issue_vj_i,
  input  logic [DATA_W-1:0] issue_vk_i,
  input  logic [TAG_W-1:0]  issue_qj_i,
  input  logic [TAG_W-1:0]  issue_qk_i,
  input  logic              cdb_valid_i,
  input  logic [TAG_W-1:0]  cdb_tag_i,
  input  logic [DATA_W-1:0] cdb_value_i,
  input  logic              dispatch_i,
  input  logic              complete_i,
  output logic              busy_o,
  output logic              ready_o,
  output logic [OP_W-1:0]   op_o,
  output logic [DATA_W-1:0] vj_o,
  output logic [DATA_W-1:0] vk_o
);

  logic              busy_q, busy_d;
  logic              exec_q, exec_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [DATA_W-1:0] vj_q, vj_d, vk_q, vk_d;
  logic [TAG_W-1:0]  qj_q, qj_d, qk_q, qk_d;

  function automatic logic hit(input logic [TAG_W-1:0] q);
    return cdb_valid_i && (q != '0) && (q == cdb_tag_i);
  endfunction

  always_comb begin
    busy_d = busy_q;
    exec_d = exec_q;
    op_d   = op_q;
    vj_d   = vj_q;
    vk_d   = vk_q;
    qj_d   = qj_q;
    qk_d   = qk_q;
    if (busy_q) begin
      if (hit(qj_q)) begin
        vj_d = cdb_value_i;
        qj_d = '0;
      end
      if (hit(qk_q)) begin
        vk_d = cdb_value_i;
        qk_d = '0;
      end
    end
    if (dispatch_i) exec_d = 1'b1;
    if (complete_i) begin
      busy_d = 1'b0;
      exec_d = 1'b0;
    end
    // Issue only targets a free entry, so it never collides with the paths above.
    if (issue_we_i) begin
      busy_d = 1'b1;
      exec_d = 1'b0;
      op_d   = issue_op_i;
      vj_d   = hit(issue_qj_i) ? cdb_value_i : issue_vj_i;
      qj_d   = hit(issue_qj_i) ? '0 : issue_qj_i;
      vk_d   = hit(issue_qk_i) ? cdb_value_i : issue_vk_i;
      qk_d   = hit(issue_qk_i) ? '0 : issue_qk_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q <= 1'b0;
      exec_q <= 1'b0;
      op_q   <= '0;
      vj_q   <= '0;
      vk_q   <= '0;
      qj_q   <= '0;
      qk_q   <= '0;
    end else begin
      busy_q <= busy_d;
      exec_q <= exec_d;
      op_q   <= op_d;
      vj_q   <= vj_d;
      vk_q   <= vk_d;
      qj_q   <= qj_d;
      qk_q   <= qk_d;
    end
  end

  assign busy_o  = busy_q;
  assign ready_o = busy_q && !exec_q && (qj_q == '0) && (qk_q == '0);
  assign op_o    = op_q;
  assign vj_o    = vj_q;
  assign vk_o    = vk_q;

endmodule

// File: rtl/estacao_reserva_r.sv
// Reservation station for the R functional unit: issue allocation, lowest-index
// dispatch to the combinational FU and a single registered CDB result slot.
module estacao_reserva_r
  import estacao_reserva_r_pkg::*;
#(
  parameter int unsigned N_ENT    = 3,
  parameter int unsigned TAG_W    = TAG_W_DEF,
  parameter int unsigned BASE_TAG = BASE_TAG_R
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              issue_valid,
  input  logic [OP_W-1:0]   issue_op,
  input  logic [DATA_W-1:0] issue_Vj,
  input  logic [DATA_W-1:0] issue_Vk,
  input  logic [TAG_W-1:0]  issue_Qj,
  input  logic [TAG_W-1:0]  issue_Qk,
  output logic [TAG_W-1:0]  issue_tag,
  output logic              full,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_value,
  output logic [OP_W-1:0]   fu_op,
  output logic [DATA_W-1:0] fu_A,
  output logic [DATA_W-1:0] fu_B,
  input  logic [DATA_W-1:0] fu_Q,
  output logic              cdb_req,
  input  logic              cdb_grant,
  output logic [TAG_W-1:0]  res_tag,
  output logic [DATA_W-1:0] res_value
);

  logic [N_ENT-1:0]  busy, ready, issue_we, dispatch, complete;
  logic [OP_W-1:0]   ent_op [N_ENT];
  logic [DATA_W-1:0] ent_vj [N_ENT];
  logic [DATA_W-1:0] ent_vk [N_ENT];

  logic              res_valid_q;
  logic [TAG_W-1:0]  res_tag_q;
  logic [DATA_W-1:0] res_value_q;

  logic              grant, slot_free, disp_any, free_found, disp_found;
  logic [TAG_W-1:0]  disp_tag;

  assign grant     = res_valid_q && cdb_grant;
  assign slot_free = !res_valid_q || cdb_grant;
  assign full      = &busy;

  always_comb begin
    issue_we   = '0;
    issue_tag  = TAG_W'(BASE_TAG);
    free_found = 1'b0;
    for (int unsigned i = 0; i < N_ENT; i++) begin
      if (!free_found && !busy[i]) begin
        free_found  = 1'b1;
        issue_tag   = TAG_W'(BASE_TAG + i);
        issue_we[i] = issue_valid;
      end
    end
  end

  always_comb begin
    dispatch   = '0;
    disp_found = 1'b0;
    disp_tag   = '0;
    fu_op      = '0;
    fu_A       = '0;
    fu_B       = '0;
    for (int unsigned i = 0; i < N_ENT; i++) begin
      if (slot_free && !disp_found && ready[i]) begin
        disp_found  = 1'b1;
        dispatch[i] = 1'b1;
        disp_tag    = TAG_W'(BASE_TAG + i);
        fu_op       = ent_op[i];
        fu_A        = ent_vj[i];
        fu_B        = ent_vk[i];
      end
    end
  end

  assign disp_any = disp_found;

  for (genvar g = 0; g < N_ENT; g++) begin : g_ent
    localparam logic [TAG_W-1:0] MY_TAG = TAG_W'(BASE_TAG + g);

    assign complete[g] = grant && (res_tag_q == MY_TAG);

    rs_entry #(.TAG_W(TAG_W)) u_entry (
      .clk_i       (Clock),
      .rst_i       (Reset),
      .issue_we_i  (issue_we[g]),
      .issue_op_i  (issue_op),
      .issue_vj_i  (issue_Vj),
      .issue_vk_i  (issue_Vk),
      .issue_qj_i  (issue_Qj),
      .issue_qk_i  (issue_Qk),
      .cdb_valid_i (cdb_valid),
      .cdb_tag_i   (cdb_tag),
      .cdb_value_i (cdb_value),
      .dispatch_i  (dispatch[g]),
      .complete_i  (complete[g]),
      .busy_o      (busy[g]),
      .ready_o     (ready[g]),
      .op_o        (ent_op[g]),
      .vj_o        (ent_vj[g]),
      .vk_o        (ent_vk[g])
    );
  end

  // A dispatch in a grant cycle reloads the slot, so it wins over the clear.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      res_valid_q <= 1'b0;
      res_tag_q   <= '0;
      res_value_q <= '0;
    end else if (disp_any) begin
      res_valid_q <= 1'b1;
      res_tag_q   <= disp_tag;
      res_value_q <= fu_Q;
    end else if (grant) begin
      res_valid_q <= 1'b0;
    end
  end

  assign cdb_req   = res_valid_q;
  assign res_tag   = res_tag_q;
  assign res_value = res_value_q;

endmodule

// File: tb/tb_estacao_reserva_r.sv
// Self-checking bench for estacao_reserva_r: directed scenarios followed by
// randomized traffic, all checked against a behavioural station model.
module tb_estacao_reserva_r;

  localparam int N  = 3;
  localparam int TW = 3;
  localparam int BT = 1;

  logic          Clock = 1'b0;
  logic          Reset;
  logic          issue_valid;
  logic [2:0]    issue_op;
  logic [15:0]   issue_Vj, issue_Vk;
  logic [TW-1:0] issue_Qj, issue_Qk;
  logic [TW-1:0] issue_tag;
  logic          full;
  logic          cdb_valid;
  logic [TW-1:0] cdb_tag;
  logic [15:0]   cdb_value;
  logic [2:0]    fu_op;
  logic [15:0]   fu_A, fu_B, fu_Q;
  logic          cdb_req;
  logic          cdb_grant;
  logic [TW-1:0] res_tag;
  logic [15:0]   res_value;

  int ntests = 0;
  int nfail  = 0;

  always #5 Clock = ~Clock;

  estacao_reserva_r #(.N_ENT(N), .TAG_W(TW), .BASE_TAG(BT)) dut (
    .Clock(Clock), .Reset(Reset),
    .issue_valid(issue_valid), .issue_op(issue_op),
    .issue_Vj(issue_Vj), .issue_Vk(issue_Vk),
    .issue_Qj(issue_Qj), .issue_Qk(issue_Qk),
    .issue_tag(issue_tag), .full(full),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .fu_op(fu_op), .fu_A(fu_A), .fu_B(fu_B), .fu_Q(fu_Q),
    .cdb_req(cdb_req), .cdb_grant(cdb_grant),
    .res_tag(res_tag), .res_value(res_value)
  );

  function automatic logic [15:0] alu(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
      3'd3:    return (a == b) ? 16'd1 : 16'd0;
      3'd4:    return b + 16'd4;
      3'd5:    return b - 16'd4;
      default: return a ^ b;
    endcase
  endfunction

  always_comb fu_Q = alu(fu_op, fu_A, fu_B);

  // Behavioural model of the station contents and the pending result.
  typedef struct {
    bit          busy;
    bit          exec;
    logic [2:0]  op;
    logic [15:0] vj, vk;
    logic [2:0]  qj, qk;
  } ent_t;

  ent_t        m [N];
  bit          m_rv;
  logic [2:0]  m_rtag;
  logic [15:0] m_rval;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int lowest_free();
    for (int i = 0; i < N; i++) if (!m[i].busy) return i;
    return -1;
  endfunction

  function automatic int pick_ready();
    if (m_rv && cdb_grant !== 1'b1) return -1;
    for (int i = 0; i < N; i++)
      if (m[i].busy && !m[i].exec && m[i].qj == 0 && m[i].qk == 0) return i;
    return -1;
  endfunction

  function automatic bit bus_hits(input logic [2:0] q);
    return cdb_valid && q != 0 && q == cdb_tag;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) m[i] = '{0, 0, 0, 0, 0, 0, 0};
    m_rv = 0; m_rtag = 0; m_rval = 0;
  endtask

  task automatic model_update();
    ent_t nx [N];
    int   f, d;
    bit   g;
    if (Reset) begin
      model_reset();
      return;
    end
    nx = m;
    f  = lowest_free();
    d  = pick_ready();
    g  = m_rv && cdb_grant;
    for (int i = 0; i < N; i++) begin
      if (m[i].busy && bus_hits(m[i].qj)) begin nx[i].vj = cdb_value; nx[i].qj = 0; end
      if (m[i].busy && bus_hits(m[i].qk)) begin nx[i].vk = cdb_value; nx[i].qk = 0; end
    end
    if (g) begin
      nx[int'(m_rtag) - BT].busy = 0;
      nx[int'(m_rtag) - BT].exec = 0;
    end
    if (d >= 0) nx[d].exec = 1;
    if (issue_valid && f >= 0) begin
      nx[f].busy = 1;
      nx[f].exec = 0;
      nx[f].op   = issue_op;
      nx[f].vj   = bus_hits(issue_Qj) ? cdb_value : issue_Vj;
      nx[f].qj   = bus_hits(issue_Qj) ? 3'd0 : issue_Qj;
      nx[f].vk   = bus_hits(issue_Qk) ? cdb_value : issue_Vk;
      nx[f].qk   = bus_hits(issue_Qk) ? 3'd0 : issue_Qk;
    end
    if (d >= 0) begin
      m_rv   = 1;
      m_rtag = 3'(BT + d);
      m_rval = alu(m[d].op, m[d].vj, m[d].vk);
    end else if (g) begin
      m_rv = 0;
    end
    m = nx;
  endtask

  task automatic idle();
    Reset = 0; issue_valid = 0; issue_op = 0; issue_Vj = 0; issue_Vk = 0;
    issue_Qj = 0; issue_Qk = 0; cdb_valid = 0; cdb_tag = 0; cdb_value = 0;
    cdb_grant = 0;
  endtask

  task automatic issue(input logic [2:0] op, input logic [15:0] vj, input logic [15:0] vk,
                       input logic [2:0] qj, input logic [2:0] qk);
    issue_valid = 1; issue_op = op; issue_Vj = vj; issue_Vk = vk; issue_Qj = qj; issue_Qk = qk;
  endtask

  // The bus carries our own result whenever we are granted.
  task automatic grant_own();
    cdb_grant = 1; cdb_valid = 1; cdb_tag = m_rtag; cdb_value = m_rval;
  endtask

  task automatic step();
    int f, d;
    #3;
    f = lowest_free();
    check("full", full, (f < 0) ? 1 : 0);
    if (f >= 0) check("issue_tag", issue_tag, BT + f);
    check("cdb_req", cdb_req, m_rv);
    if (m_rv) begin
      check("res_tag", res_tag, m_rtag);
      check("res_value", res_value, m_rval);
    end
    d = pick_ready();
    check("fu_op", fu_op, (d >= 0) ? m[d].op : 0);
    check("fu_A", fu_A, (d >= 0) ? m[d].vj : 0);
    check("fu_B", fu_B, (d >= 0) ? m[d].vk : 0);
    @(posedge Clock);
    model_update();
    #1;
    idle();
  endtask

  initial begin
    int r, k;
    idle();
    Reset = 1;
    @(posedge Clock);
    model_reset();
    #1;
    Reset = 0;
    check("rst_cdb_req", cdb_req, 0);
    check("rst_full", full, 0);
    check("rst_res_tag", res_tag, 0);
    check("rst_res_value", res_value, 0);
    check("rst_fu_op", fu_op, 0);
    check("rst_fu_A", fu_A, 0);
    check("rst_fu_B", fu_B, 0);
    check("rst_issue_tag", issue_tag, 1);

    // Ready add: result one cycle after dispatch.
    issue(3'd0, 16'd5, 16'd7, 0, 0); step();
    check("t1_no_req_yet", cdb_req, 0);
    step();
    check("t1_req", cdb_req, 1);
    check("t1_value", res_value, 12);
    check("t1_tag", res_tag, 1);
    grant_own(); step();
    check("t1_freed_full", full, 0);
    check("t1_freed_req", cdb_req, 0);

    // Sub waiting on an external producer.
    issue(3'd1, 16'hdead, 16'd2, 3'd3, 0); step();
    step(); step();
    check("t2_no_early", cdb_req, 0);
    cdb_valid = 1; cdb_tag = 3'd3; cdb_value = 16'd10; step();
    check("t2_still_waiting", cdb_req, 0);
    step();
    check("t2_value", res_value, 8);
    check("t2_tag", res_tag, 1);
    grant_own(); step();

    // Issue-time bypass of Qk, op B+4.
    issue(3'd4, 16'd0, 16'hbeef, 0, 3'd2);
    cdb_valid = 1; cdb_tag = 3'd2; cdb_value = 16'd9; step();
    step();
    check("t3_req", cdb_req, 1);
    check("t3_value", res_value, 13);
    grant_own(); step();

    // Fill, drop the overflow issue, hold without grant, then drain.
    issue(3'd0, 16'd1, 16'd1, 0, 0); step();
    issue(3'd0, 16'd2, 16'd2, 0, 0); step();
    issue(3'd0, 16'd3, 16'd3, 0, 0); step();
    check("t4_full", full, 1);
    issue(3'd0, 16'd9, 16'd9, 0, 0); step();
    for (int i = 0; i < 5; i++) begin
      step();
      check("t4_hold_tag", res_tag, 1);
      check("t4_hold_req", cdb_req, 1);
    end
    for (int i = 0; i < 3; i++) begin
      check("t4_drain_tag", res_tag, 1 + i);
      check("t4_drain_value", res_value, 2 * (1 + i));
      grant_own(); step();
    end
    check("t4_empty_req", cdb_req, 0);
    check("t4_empty_full", full, 0);

    // Sibling dependency through our own broadcast.
    issue(3'd2, 16'd3, 16'd4, 0, 0); step();
    issue(3'd0, 16'd0, 16'd10, 3'd1, 0); step();
    check("t5_slt", res_value, 1);
    grant_own(); step();
    step();
    check("t5_dep_tag", res_tag, 2);
    check("t5_dep_value", res_value, 11);
    grant_own(); step();

    // Reset with a pending result.
    issue(3'd0, 16'd2, 16'd3, 0, 0); step();
    step();
    check("t6_pending", cdb_req, 1);
    Reset = 1; step();
    check("t6_req", cdb_req, 0);
    check("t6_full", full, 0);
    check("t6_tag", issue_tag, 1);
    issue(3'd1, 16'd9, 16'd4, 0, 0); step();
    step();
    check("t6_new_tag", res_tag, 1);
    check("t6_new_value", res_value, 5);

    // Randomized traffic against the model.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(0, 299) == 0) Reset = 1;
      if ($urandom_range(0, 2) != 0) begin
        issue(3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom), 0, 0);
        for (int s = 0; s < 2; s++) begin
          r = $urandom_range(0, 9);
          if (r >= 7) begin
            k = $urandom_range(0, N - 1);
            r = m[k].busy ? BT + k : 0;
          end else if (r >= 5) r = $urandom_range(4, 7);
          else r = 0;
          if (s == 0) issue_Qj = 3'(r); else issue_Qk = 3'(r);
        end
      end
      if (m_rv && $urandom_range(0, 1) == 1) grant_own();
      else begin
        if (!m_rv && $urandom_range(0, 7) == 0) cdb_grant = 1;
        if ($urandom_range(0, 2) == 0) begin
          cdb_valid = 1;
          cdb_tag   = ($urandom_range(0, 4) == 0) ? 3'd0 : 3'($urandom_range(4, 7));
          cdb_value = 16'($urandom);
        end
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/estacao_reserva_r.md
Name: estacao_reserva_r

Overview:
- Reservation station for the R-type functional unit (16-bit datapath, Tomasulo-style issue).
- Accepts issued ops with operand values or producer tags and snoops the common data bus (CDB) for missing operands.
- Dispatches ready ops to the combinational R unit (3-bit Ulaop: 0 add, 1 sub, 2 slt, 3 cmp, 4 B+4, 5 B-4).
- Registers the result and requests the CDB to broadcast it.

Parameters:
N_ENT, 3, number of station entries (1..7)
TAG_W, 3, tag width; tag 0 means "value present, no producer"
BASE_TAG, 1, tag of entry 0; entry i owns tag BASE_TAG+i (must be nonzero, must not overflow TAG_W)

Ports:
Clock  in  1  rising-edge clock
Reset  in  1  synchronous, active-high reset
issue_valid  in  1  issue request this cycle
issue_op  in  3  Ulaop of issued instruction
issue_Vj, issue_Vk  in  16  operand values (used when matching Q is 0)
issue_Qj, issue_Qk  in  TAG_W  producer tags (0 = value valid)
issue_tag  out  TAG_W  tag assigned to the accepted issue (combinational, valid when !full)
full  out  1  all entries busy; issue ignored
cdb_valid  in  1  CDB broadcast valid
cdb_tag  in  TAG_W  broadcasting producer tag
cdb_value  in  16  broadcast value
fu_op  out  3  Ulaop to functional unit
fu_A, fu_B  out  16  operands to functional unit
fu_Q  in  16  functional unit result (combinational)
cdb_req  out  1  result pending, request bus
cdb_grant  in  1  bus granted this cycle
res_tag  out  TAG_W  tag of pending result
res_value  out  16  pending result value

Behaviour:
- Reset: all entries not busy or executing, Q fields 0. res_valid=0, so cdb_req=0; res_tag=0, res_value=0; fu_op/fu_A/fu_B=0; full=0.
- Entry fields: busy, exec, op, Vj, Vk, Qj, Qk.
- Issue: if issue_valid && !full, write the lowest-index free entry at the clock edge; busy=1, exec=0. issue_valid while full is dropped (no state change).
- Issue/CDB bypass: if issue_Qj!=0 and cdb_valid && cdb_tag==issue_Qj in the same cycle, store Vj=cdb_value, Qj=0. Same for k. Both operands may be bypassed in one cycle.
- Snoop: every busy entry with Qx!=0 && Qx==cdb_tag && cdb_valid loads Vx=cdb_value and sets Qx=0. Tag 0 on the CDB never matches.
- Ready: busy && !exec && Qj==0 && Qk==0, evaluated on registered state. An op that became ready this edge dispatches no earlier than the next cycle.
- Dispatch slot is free when res_valid==0, or when res_valid && cdb_grant in this cycle (back-to-back).
- Dispatch: if the slot is free and any entry is ready, select the lowest-index ready entry and drive fu_op/fu_A/fu_B from it combinationally. At the edge: res_value<=fu_Q, res_tag<=entry tag, res_valid<=1, entry exec<=1. If nothing is dispatched, fu_* hold 0.
- Latency: operands complete at edge t -> dispatch in cycle t -> cdb_req high from t+1.
- Completion: in a cdb_req && cdb_grant cycle, the owning entry clears busy and exec at the edge. res_valid clears unless a new dispatch reloads it the same edge.
- Without a grant, res_* and cdb_req hold stable indefinitely.
- The freed entry is reusable by issue on the following cycle. full is computed from registered busy bits.
- The station snoops its own broadcasts: an entry waiting on a sibling's tag captures the value when the sibling is granted.
- cdb_grant while cdb_req==0 is ignored.
- Reset mid-operation discards all entries and the pending result; no broadcast is emitted.
- Ops 6/7 are dispatched unchanged; the result is whatever fu_Q returns. Filtering these is the decoder's job.
- All arithmetic is 16-bit wrap-around, done in the FU; the station only moves values.

Decomposition:
- Shared package/header: Ulaop encodings (ULA_ADD..ULA_SUB4), TAG_W, tag-0 NULL constant, per-unit BASE_TAG values.
- One natural sub-module: rs_entry (single-entry storage + snoop/bypass logic), instantiated N_ENT times.
- Priority select and the result register stay in the top module.

Test Plan:
1. Issue add, Vj=5, Vk=7, Qj=Qk=0 -> one cycle later cdb_req=1, res_value=12, res_tag=1; grant -> entry freed, full=0.
2. Issue sub with Qj=3, Vk=2; then CDB tag 3 value 10 -> dispatch next cycle; res_value=8; no dispatch before the broadcast.
3. Issue with Qk=2 in the same cycle as cdb_valid tag 2 value 9 (bypass), op B+4 -> res_value=13, no extra wait.
4. Fill 3 entries, all ready -> full=1; 4th issue ignored. cdb_grant withheld 5 cycles -> res_tag=1 held stable. Grants each cycle -> tags 1,2,3 broadcast in consecutive cycles.
5. Entry 2 waits on tag 1 (sibling, slt 3<4); grant of tag 1 value 1 -> entry 2 captures 1, then broadcasts.
6. Reset asserted while cdb_req=1 -> next cycle cdb_req=0, full=0, all entries empty; a following issue gets tag 1.
